// File: rtl/reg_file_p_pkg.sv
// Shared CPU package: register-file opcode set.
// Used by the register file, the ALU and the control unit.
package reg_file_p_pkg;

  typedef enum logic [2:0] {
    FS_HOLD  = 3'b000,
    FS_LOAD  = 3'b001,
    FS_CLEAR = 3'b010,
    FS_INC   = 3'b011,
    FS_DEC   = 3'b100,
    FS_SHL   = 3'b101,
    FS_SHR   = 3'b110,
    FS_ROL   = 3'b111
  } funsel_e;

  localparam int FUNSEL_W = 3;

endpackage

// File: rtl/reg_file_p_reg_cell.sv
// Next-state logic for one register of the file.
// Purely combinational; the storage flop lives in the top.
module reg_cell
  import reg_file_p_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  funsel_e          funsel,
  input  logic             we,
  input  logic [WIDTH-1:0] load,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    if (we) begin
      unique case (funsel)
        FS_HOLD:  nxt = cur;
        FS_LOAD:  nxt = load;
        FS_CLEAR: nxt = '0;
        FS_INC: begin
          nxt  = cur + ONE;
          wrap = &cur;
        end
        FS_DEC: begin
          nxt  = cur - ONE;
          wrap = ~|cur;
        end
        FS_SHL:   nxt = {cur[WIDTH-2:0], 1'b0};
        FS_SHR:   nxt = {1'b0, cur[WIDTH-1:1]};
        FS_ROL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
        default:  nxt = cur;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_p.sv
// Multi-write register file with per-register opcode cells,
// two combinational read ports, registered wrap and zero flags.
module reg_file_p
  import reg_file_p_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               funsel,
  input  logic [DEPTH-1:0]         rsel,
  input  logic [WIDTH-1:0]         load,
  input  logic [$clog2(DEPTH)-1:0] o1sel,
  input  logic [$clog2(DEPTH)-1:0] o2sel,
  output logic [WIDTH-1:0]         o1,
  output logic [WIDTH-1:0]         o2,
  output logic                     wrap,
  output logic [DEPTH-1:0]         zero
);

  logic [WIDTH-1:0] reg_q [DEPTH];
  logic [WIDTH-1:0] reg_d [DEPTH];
  logic [DEPTH-1:0] wrap_v;
  logic [DEPTH-1:0] zero_d, zero_q;
  logic             wrap_d, wrap_q;
  funsel_e          op;

  assign op = funsel_e'(funsel);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    reg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .funsel (op),
      .we     (rsel[i]),
      .load   (load),
      .cur    (reg_q[i]),
      .nxt    (reg_d[i]),
      .wrap   (wrap_v[i])
    );
  end

  // Flags track the next-state value so they line up with reg_q
  always_comb begin
    wrap_d = |wrap_v;
    zero_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      zero_d[i] = (reg_d[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
      end
      zero_q <= '1;
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= reg_d[i];
      end
      zero_q <= zero_d;
      wrap_q <= wrap_d;
    end
  end

  assign o1   = reg_q[o1sel];
  assign o2   = reg_q[o2sel];
  assign wrap = wrap_q;
  assign zero = zero_q;

endmodule

// File: doc/reg_file_p.md
REG_FILE_P -- requirements
Module: reg_file_p

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of registers (power of 2, legal range 2..16).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port funsel, input, 3, meaning the operation code applied to every selected register.
REQ-006 The block SHALL have port rsel, input, DEPTH, meaning a one-hot-or-multi-hot write mask; bit i selects register i.
REQ-007 The block SHALL have port load, input, WIDTH, meaning load data for LOAD.
REQ-008 The block SHALL have ports o1sel and o2sel, input, log2(DEPTH) each, meaning read addresses.
REQ-009 The block SHALL have ports o1 and o2, output, WIDTH each, meaning combinational read data.
REQ-010 The block SHALL have port wrap, output, 1, meaning a registered flag for INC/DEC wrap on any selected register.
REQ-011 The block SHALL have port zero, output, DEPTH, meaning a registered per-register flag that the register equals 0.

Function
REQ-012 funsel encoding SHALL be: 000 HOLD, 001 LOAD, 010 CLEAR, 011 INC, 100 DEC, 101 SHL (LSB<-0), 110 SHR (MSB<-0), 111 ROL (LSB<-old MSB).
REQ-013 At each edge, every register with rsel[i]=1 SHALL take the funsel result; registers with rsel[i]=0 SHALL hold.
REQ-014 rsel=0 or funsel=HOLD SHALL leave all registers unchanged and SHALL clear wrap.
REQ-015 INC SHALL wrap modulo 2^WIDTH (all-ones -> 0); DEC SHALL wrap modulo 2^WIDTH (0 -> all-ones).
REQ-016 wrap SHALL be 1 for exactly the cycle after an edge where at least one selected register wrapped under INC/DEC; otherwise 0.
REQ-017 o1/o2 SHALL reflect the register contents at the current cycle; there is no write-to-read bypass, so a same-cycle write becomes visible after the edge.
REQ-018 o1sel equal to o2sel SHALL return identical data on both ports.
REQ-019 zero[i] SHALL be updated every edge from the next-state value of register i, so that zero is consistent with register contents at every cycle.
REQ-020 A multi-hot rsel SHALL apply the same operation independently to each selected register in a single cycle.

Reset
REQ-021 rst=1 at a rising edge SHALL clear all registers to 0, set zero to all-ones, and clear wrap, overriding funsel/rsel.
REQ-022 A reset asserted mid-sequence SHALL discard the in-flight operation for that edge; operation resumes on the first edge with rst=0.
REQ-023 Before the first reset, register contents are undefined; verification SHALL start only after one reset cycle.

Structure
REQ-024 The funsel opcode constants SHALL be placed in the shared CPU package so that the ALU and control unit use the same definitions.
REQ-025 Per-register next-state logic SHALL be one sub-module, reg_cell, with the same opcode set, an external write enable, and a wrap output, instantiated DEPTH times by generate.
REQ-026 The read muxes, the wrap OR-reduction and the zero flags SHALL reside in reg_file_p.

Verification (WIDTH=8, DEPTH=8)
REQ-027 Reset, then o1sel=0..7 sweep -> o1=0x00 for all, zero=0xFF, wrap=0.
REQ-028 rsel=0x10, LOAD 0x95; next cycle o1sel=4 -> o1=0x95, zero=0xEF; then SHL -> 0x2A, then ROL -> 0x54.
REQ-029 LOAD 0xFF into R2, INC on rsel=0x04 -> R2=0x00, wrap=1 for one cycle, zero[2]=1; following HOLD -> wrap=0.
REQ-030 rsel=0x81, DEC from reset -> R0=R7=0xFF, wrap=1, other registers 0; o1sel=0, o2sel=7 -> both 0xFF.
REQ-031 LOAD 0x33 with rsel=0x02 while o1sel=1 -> o1=old value (0x00) in the write cycle, 0x33 after the edge.
REQ-032 Registers loaded with nonzero values, rst=1 in the same cycle as INC -> all registers 0x00, wrap=0, zero=0xFF.
